// File: rtl/sprite_line_streamer.sv
// Three-sprite line streamer: fetches one pattern row per sprite for the next line, then
// composites A/B/C with fixed priority. Optional sticky collision detection under SPRITE_COLLISION_EN.
module sprite_line_streamer #(
  parameter int SPR_SIZE = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic [7:0]          vpos,
  input  logic                active,
  input  logic [7:0]          hpos,
  input  logic [23:0]         sp_x,
  input  logic [23:0]         sp_y,
  output logic                rd_req,
  output logic [1:0]          rd_sprite,
  output logic [3:0]          rd_row,
  input  logic                rd_ack,
  input  logic [SPR_SIZE-1:0] rd_data,
  output logic                pix_valid,
  output logic [1:0]          pix_id,
  output logic                fetch_busy,
  output logic                late_flag,
`ifdef SPRITE_COLLISION_EN
  output logic                collision,
  output logic                coll_irq,
`endif
  input  logic                clr_flags
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [1:0]          n_r;
  logic [7:0]          vpos_r;
  logic [SPR_SIZE-1:0] row_buf_r  [3];
  logic [SPR_SIZE-1:0] disp_buf_r [3];
  logic                blank_r;

  logic [7:0] dy_s;
  logic       hit_s;
  logic       abort_s;
  logic [2:0] opq_s;
  logic       blank_s;
  logic       late_set_s;

  function automatic logic [7:0] coord_sel(input logic [23:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    coord_sel = v[7:0];
      2'd1:    coord_sel = v[15:8];
      2'd2:    coord_sel = v[23:16];
      default: coord_sel = 8'd0;
    endcase
  endfunction

  // dx is already mod-256, so a sprite straddling x=255 wraps naturally.
  function automatic logic opaque(input logic [SPR_SIZE-1:0] row, input logic [7:0] dx);
    logic [15:0] ext;
    logic [3:0]  idx;
    ext    = 16'(row);
    idx    = 4'(SPR_SIZE - 1) - dx[3:0];
    opaque = (dx < 8'(SPR_SIZE)) && ext[idx];
  endfunction

  // Row selection for the sprite under test and per-pixel opacity.
  always_comb begin
    dy_s       = vpos_r - coord_sel(sp_y, n_r);
    hit_s      = (dy_s < 8'(SPR_SIZE));
    abort_s    = line_start && (state_r != IDLE);
    opq_s[0]   = opaque(disp_buf_r[0], hpos - sp_x[7:0]);
    opq_s[1]   = opaque(disp_buf_r[1], hpos - sp_x[15:8]);
    opq_s[2]   = opaque(disp_buf_r[2], hpos - sp_x[23:16]);
    blank_s    = blank_r || fetch_busy;
    late_set_s = abort_s || (active && fetch_busy);
  end

  // Fetch sequencer; a line_start in any state restarts from sprite A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      n_r        <= 2'd0;
      vpos_r     <= 8'd0;
      rd_req     <= 1'b0;
      rd_sprite  <= 2'd0;
      rd_row     <= 4'd0;
      fetch_busy <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        row_buf_r[i]  <= '0;
        disp_buf_r[i] <= '0;
      end
    end else if (line_start) begin
      state_r    <= CHECK;
      n_r        <= 2'd0;
      vpos_r     <= vpos;
      rd_req     <= 1'b0;
      fetch_busy <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          fetch_busy <= 1'b0;
        end
        CHECK: begin
          if (hit_s) begin
            state_r   <= REQ;
            rd_req    <= 1'b1;
            rd_sprite <= n_r;
            rd_row    <= dy_s[3:0];
          end else begin
            row_buf_r[n_r] <= '0;
            state_r        <= NEXT;
          end
        end
        REQ: begin
          if (rd_ack) begin
            row_buf_r[n_r] <= rd_data;
            rd_req         <= 1'b0;
            state_r        <= NEXT;
          end else begin
            state_r <= REQ;
          end
        end
        NEXT: begin
          if (n_r == 2'd2) begin
            state_r <= DONE;
          end else begin
            n_r     <= n_r + 2'd1;
            state_r <= CHECK;
          end
        end
        DONE: begin
          for (int i = 0; i < 3; i++) begin
            disp_buf_r[i] <= row_buf_r[i];
          end
          state_r    <= IDLE;
          fetch_busy <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          rd_req     <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

  // Pixel output; a late fetch blanks the remainder of the current active window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_id    <= 2'd0;
      blank_r   <= 1'b0;
    end else if (!active) begin
      pix_valid <= 1'b0;
      pix_id    <= 2'd0;
      blank_r   <= 1'b0;
    end else begin
      blank_r <= blank_s;
      if (blank_s) begin
        pix_valid <= 1'b0;
        pix_id    <= 2'd0;
      end else if (opq_s[0]) begin
        pix_valid <= 1'b1;
        pix_id    <= 2'd0;
      end else if (opq_s[1]) begin
        pix_valid <= 1'b1;
        pix_id    <= 2'd1;
      end else if (opq_s[2]) begin
        pix_valid <= 1'b1;
        pix_id    <= 2'd2;
      end else begin
        pix_valid <= 1'b0;
        pix_id    <= 2'd0;
      end
    end
  end

  // Sticky late flag; a new set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late_flag <= 1'b0;
    end else if (late_set_s) begin
      late_flag <= 1'b1;
    end else if (clr_flags) begin
      late_flag <= 1'b0;
    end else begin
      late_flag <= late_flag;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic coll_set_s;

  // Two or more opaque sprites on one visible pixel.
  always_comb begin
    coll_set_s = active && ((opq_s[0] && opq_s[1]) || (opq_s[0] && opq_s[2]) ||
                            (opq_s[1] && opq_s[2]));
  end

  // Sticky collision flag, same set-over-clear rule as late_flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else if (coll_set_s) begin
      collision <= 1'b1;
    end else if (clr_flags) begin
      collision <= 1'b0;
    end else begin
      collision <= collision;
    end
  end

  assign coll_irq = collision;
`endif

endmodule

// File: tb/tb_sprite_line_streamer.sv
// Directed bench for sprite_line_streamer: fetch handshake, priority, wrap, late/abort flags, reset.
module tb_sprite_line_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [7:0]  vpos;
  logic        active;
  logic [7:0]  hpos;
  logic [23:0] sp_x;
  logic [23:0] sp_y;
  logic        rd_req;
  logic [1:0]  rd_sprite;
  logic [3:0]  rd_row;
  logic        rd_ack;
  logic [11:0] rd_data;
  logic        pix_valid;
  logic [1:0]  pix_id;
  logic        fetch_busy;
  logic        late_flag;
  logic        clr_flags;
`ifdef SPRITE_COLLISION_EN
  logic        collision;
  logic        coll_irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int extra;

  sprite_line_streamer #(.SPR_SIZE(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .vpos       (vpos),
    .active     (active),
    .hpos       (hpos),
    .sp_x       (sp_x),
    .sp_y       (sp_y),
    .rd_req     (rd_req),
    .rd_sprite  (rd_sprite),
    .rd_row     (rd_row),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .pix_valid  (pix_valid),
    .pix_id     (pix_id),
    .fetch_busy (fetch_busy),
    .late_flag  (late_flag),
`ifdef SPRITE_COLLISION_EN
    .collision  (collision),
    .coll_irq   (coll_irq),
`endif
    .clr_flags  (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_line_start();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_req(input logic [1:0] s, input logic [3:0] row);
    for (int i = 0; i < 20; i++) begin
      if (rd_req) break;
      @(negedge clk);
    end
    chk("req_seen", 32'(rd_req), 32'd1);
    chk("req_sprite", 32'(rd_sprite), 32'(s));
    chk("req_row", 32'(rd_row), 32'(row));
  endtask

  task automatic serve(input logic [1:0] s, input logic [3:0] row, input logic [11:0] data,
                       input int delay);
    wait_req(s, row);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(rd_req), 32'd1);
      chk("hold_sprite", 32'(rd_sprite), 32'(s));
      chk("hold_row", 32'(rd_row), 32'(row));
    end
    rd_ack  = 1'b1;
    rd_data = data;
    @(negedge clk);
    rd_ack  = 1'b0;
    rd_data = 12'h0F0;
    chk("req_drop", 32'(rd_req), 32'd0);
  endtask

  task automatic wait_idle(output int n_extra);
    n_extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (!fetch_busy) break;
      if (rd_req) n_extra++;
      @(negedge clk);
    end
    chk("fetch_idle", 32'(fetch_busy), 32'd0);
  endtask

  task automatic pix(input logic [7:0] h, input logic v, input logic [1:0] id);
    active = 1'b1;
    hpos   = h;
    @(negedge clk);
    chk($sformatf("pix_valid@%0d", h), 32'(pix_valid), 32'(v));
    chk($sformatf("pix_id@%0d", h), 32'(pix_id), 32'(id));
  endtask

  initial begin
    rst_n = 1'b0; line_start = 1'b0; vpos = 8'd0; active = 1'b0; hpos = 8'd0;
    sp_x = 24'd0; sp_y = 24'd0; rd_ack = 1'b0; rd_data = 12'h0F0; clr_flags = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_late", 32'(late_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // A hits row 5 with a 7-cycle ack delay; B and C miss.
    sp_y = {8'd100, 8'd100, 8'd10};
    sp_x = {8'd100, 8'd20, 8'd20};
    vpos = 8'd15;
    pulse_line_start();
    chk("busy_after_start", 32'(fetch_busy), 32'd1);
    serve(2'd0, 4'd5, 12'hA5F, 7);
    wait_idle(extra);
    chk("no_extra_req", 32'(extra), 32'd0);
    chk("late_clean", 32'(late_flag), 32'd0);
    pix(8'd20, 1'b1, 2'd0);
    pix(8'd21, 1'b0, 2'd0);
    pix(8'd22, 1'b1, 2'd0);
    pix(8'd24, 1'b0, 2'd0);
    pix(8'd25, 1'b1, 2'd0);
    pix(8'd31, 1'b1, 2'd0);
    pix(8'd32, 1'b0, 2'd0);
    active = 1'b0;
    @(negedge clk);
    chk("inactive_pix", 32'(pix_valid), 32'd0);

    // All three sprites hit; A/B/C overlap near x=20 to exercise priority.
    sp_y = {8'd14, 8'd12, 8'd10};
    sp_x = {8'd18, 8'd20, 8'd20};
    pulse_line_start();
    serve(2'd0, 4'd5, 12'h800, 0);
    serve(2'd1, 4'd3, 12'hC00, 0);
    serve(2'd2, 4'd1, 12'hFFF, 0);
    wait_idle(extra);
    pix(8'd17, 1'b0, 2'd0);
`ifdef SPRITE_COLLISION_EN
    chk("coll_clear", 32'(collision), 32'd0);
`endif
    pix(8'd20, 1'b1, 2'd0);
`ifdef SPRITE_COLLISION_EN
    chk("coll_set", 32'(collision), 32'd1);
    chk("coll_irq", 32'(coll_irq), 32'd1);
`endif
    pix(8'd21, 1'b1, 2'd1);
    pix(8'd22, 1'b1, 2'd2);
    pix(8'd18, 1'b1, 2'd2);
    active = 1'b0;
    @(negedge clk);

    // Horizontal wrap: A at x=250, full row.
    sp_y = {8'd100, 8'd100, 8'd15};
    sp_x = {8'd100, 8'd100, 8'd250};
    pulse_line_start();
    serve(2'd0, 4'd0, 12'hFFF, 2);
    wait_idle(extra);
    pix(8'd249, 1'b0, 2'd0);
    pix(8'd250, 1'b1, 2'd0);
    pix(8'd255, 1'b1, 2'd0);
    pix(8'd0, 1'b1, 2'd0);
    pix(8'd5, 1'b1, 2'd0);
    pix(8'd6, 1'b0, 2'd0);
    active = 1'b0;
    @(negedge clk);
`ifdef SPRITE_COLLISION_EN
    chk("coll_sticky", 32'(collision), 32'd1);
`endif

    // Abort mid-request with a simultaneous clear: the set must win.
    sp_y = {8'd100, 8'd100, 8'd10};
    sp_x = {8'd100, 8'd100, 8'd20};
    pulse_line_start();
    wait_req(2'd0, 4'd5);
    line_start = 1'b1;
    clr_flags  = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    clr_flags  = 1'b0;
    chk("abort_req_drop", 32'(rd_req), 32'd0);
    chk("abort_busy", 32'(fetch_busy), 32'd1);
    chk("late_set_wins", 32'(late_flag), 32'd1);
    serve(2'd0, 4'd5, 12'hFFF, 0);
    wait_idle(extra);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("late_cleared", 32'(late_flag), 32'd0);
`ifdef SPRITE_COLLISION_EN
    chk("coll_cleared", 32'(collision), 32'd0);
`endif

    // Active window opens while the fetch is stalled.
    pulse_line_start();
    wait_req(2'd0, 4'd5);
    active = 1'b1;
    hpos   = 8'd20;
    @(negedge clk);
    chk("late_on_active", 32'(late_flag), 32'd1);
    chk("late_pix_blank", 32'(pix_valid), 32'd0);
    hpos = 8'd22;
    @(negedge clk);
    chk("late_pix_blank2", 32'(pix_valid), 32'd0);
    rd_ack  = 1'b1;
    rd_data = 12'hFFF;
    @(negedge clk);
    rd_ack  = 1'b0;
    rd_data = 12'h0F0;
    hpos    = 8'd20;
    wait_idle(extra);
    pix(8'd20, 1'b0, 2'd0);
    active = 1'b0;
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("late_clr", 32'(late_flag), 32'd0);
    pix(8'd20, 1'b1, 2'd0);

    // Reset in the middle of a handshake.
    active = 1'b0;
    @(negedge clk);
    pulse_line_start();
    wait_req(2'd0, 4'd5);
    active = 1'b1;
    hpos   = 8'd20;
    @(negedge clk);
    chk("pre_rst_late", 32'(late_flag), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_req", 32'(rd_req), 32'd0);
    chk("async_busy", 32'(fetch_busy), 32'd0);
    chk("async_row", 32'(rd_row), 32'd0);
    chk("async_late", 32'(late_flag), 32'd0);
    chk("async_pix", 32'(pix_valid), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    active = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(fetch_busy), 32'd0);
    pix(8'd20, 1'b0, 2'd0);
    pix(8'd25, 1'b0, 2'd0);
    active = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
